// File: rtl/prime_pkg.sv
// Shared types and helpers for the prime picker: FSM state encoding, Galois LFSR
// tap masks for widths 3..16, and the score-to-candidate-mask mapping.
package prime_pkg;

    typedef enum logic [1:0] {IDLE, CHECK, TEST, NEXT} state_t;

    // Right-shifting Galois feedback masks for maximal-length sequences.
    function automatic logic [15:0] lfsr_taps(input int unsigned w);
        case (w)
            3:       lfsr_taps = 16'h0006;
            4:       lfsr_taps = 16'h000C;
            5:       lfsr_taps = 16'h0014;
            6:       lfsr_taps = 16'h0030;
            7:       lfsr_taps = 16'h0060;
            8:       lfsr_taps = 16'h00B8;
            9:       lfsr_taps = 16'h0110;
            10:      lfsr_taps = 16'h0240;
            11:      lfsr_taps = 16'h0500;
            12:      lfsr_taps = 16'h0829;
            13:      lfsr_taps = 16'h100D;
            14:      lfsr_taps = 16'h2015;
            15:      lfsr_taps = 16'h6000;
            16:      lfsr_taps = 16'hD008;
            default: lfsr_taps = 16'h0006;
        endcase
    endfunction

    function automatic logic [31:0] level_mask(input logic [31:0] score,
                                               input int unsigned shift,
                                               input int unsigned levels,
                                               input int unsigned min_bits,
                                               input int unsigned width);
        int unsigned lvl;
        int unsigned bits;
        lvl = score >> shift;
        if (lvl > levels - 1) lvl = levels - 1;
        bits = min_bits + lvl;
        if (bits > width) bits = width;
        level_mask = (32'd1 << bits) - 32'd1;
    endfunction

endpackage

// File: rtl/lfsr_galois.sv
// Free-running Galois LFSR; a zero seed would lock up, so it is replaced by 1.
module lfsr_galois
    import prime_pkg::*;
#(
    parameter int unsigned      WIDTH = 7,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] state
);

    localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));
    localparam logic [WIDTH-1:0] INIT = (SEED == '0) ? WIDTH'(1) : SEED;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= INIT;
        else     state <= (state >> 1) ^ (state[0] ? TAPS : '0);
    end

endmodule

// File: rtl/prime_picker.sv
// Finds the first prime at or above a masked start candidate by trial division,
// wrapping the search from the top of the WIDTH range back to 2.
module prime_picker
    import prime_pkg::*;
#(
    parameter int unsigned      WIDTH       = 7,
    parameter int unsigned      SCORE_W     = 7,
    parameter int unsigned      LEVELS      = 4,
    parameter int unsigned      LEVEL_SHIFT = 2,
    parameter int unsigned      MIN_BITS    = 4,
    parameter logic [WIDTH-1:0] SEED        = WIDTH'(7'h5A)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req,
    input  logic               mode,
    input  logic [WIDTH-1:0]   cand_in,
    input  logic [SCORE_W-1:0] score,
    output logic [WIDTH-1:0]   prime_out,
    output logic               valid,
    output logic               busy
);

    state_t                 state;
    logic [WIDTH-1:0]       n;
    logic [WIDTH-1:0]       d;
    logic [WIDTH-1:0]       lfsr_state;
    logic [WIDTH-1:0]       cand;
    logic [WIDTH-1:0]       n_mod_d;
    logic [2*WIDTH-1:0]     d_sq;

    lfsr_galois #(
        .WIDTH (WIDTH),
        .SEED  (SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .state (lfsr_state)
    );

    assign cand    = (mode ? cand_in : lfsr_state)
                   & WIDTH'(level_mask(32'(score), LEVEL_SHIFT, LEVELS, MIN_BITS, WIDTH));
    assign d_sq    = {{WIDTH{1'b0}}, d} * {{WIDTH{1'b0}}, d};
    assign n_mod_d = n % d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            n         <= '0;
            d         <= WIDTH'(3);
            prime_out <= '0;
            valid     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        n     <= cand;
                        busy  <= 1'b1;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (n < WIDTH'(2)) begin
                        n         <= WIDTH'(2);
                        prime_out <= WIDTH'(2);
                        valid     <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (n == WIDTH'(2) || n == WIDTH'(3)) begin
                        prime_out <= n;
                        valid     <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (!n[0]) begin
                        state <= NEXT;
                    end else begin
                        d     <= WIDTH'(3);
                        state <= TEST;
                    end
                end
                TEST: begin
                    // Divisor past sqrt(n) without a hit means n is prime.
                    if (d_sq > {{WIDTH{1'b0}}, n}) begin
                        prime_out <= n;
                        valid     <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (n_mod_d == '0) begin
                        state <= NEXT;
                    end else begin
                        d <= d + WIDTH'(2);
                    end
                end
                NEXT: begin
                    n     <= (n == '1) ? WIDTH'(2) : n + WIDTH'(1);
                    state <= CHECK;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prime_picker.sv
// Directed bench for prime_picker: default 7-bit instance plus a 4-bit instance for wrap.
module tb_prime_picker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       req, mode, valid, busy;
    logic [6:0] cand_in, score, prime_out;
    logic       req4, mode4, v4, b4;
    logic [3:0] cand4, p4;
    logic [6:0] score4;

    int total = 0;
    int bad   = 0;

    prime_picker dut (
        .clk(clk), .rst(rst), .req(req), .mode(mode), .cand_in(cand_in), .score(score),
        .prime_out(prime_out), .valid(valid), .busy(busy)
    );

    prime_picker #(.WIDTH(4), .MIN_BITS(4), .SEED(4'hA)) dut4 (
        .clk(clk), .rst(rst), .req(req4), .mode(mode4), .cand_in(cand4), .score(score4),
        .prime_out(p4), .valid(v4), .busy(b4)
    );

    // Reference 7-bit maximal Galois LFSR (x^7 + x^6 + 1), seeded 0x5A.
    logic [6:0] lf;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) lf <= 7'h5A;
        else     lf <= (lf >> 1) ^ (lf[0] ? 7'h60 : 7'h00);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit is_prime(input int n);
        if (n < 2) return 1'b0;
        for (int k = 2; k * k <= n; k++) if (n % k == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int ref_prime(input int start, input int w);
        int n;
        int maxv;
        n = start;
        maxv = (1 << w) - 1;
        if (n < 2) return 2;
        for (int i = 0; i < (1 << w) + 2; i++) begin
            if (is_prime(n)) return n;
            n = (n == maxv) ? 2 : n + 1;
        end
        return -1;
    endfunction

    function automatic int mask_of(input int s);
        int lvl;
        int bits;
        lvl = s >> 2;
        if (lvl > 3) lvl = 3;
        bits = 4 + lvl;
        if (bits > 7) bits = 7;
        return (1 << bits) - 1;
    endfunction

    task automatic issue(input logic m, input logic [6:0] c, input logic [6:0] s);
        mode = m; cand_in = c; score = s; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic wait_valid(input string tag, output logic [6:0] p);
        p = '0;
        for (int i = 0; i < 3000 && !valid; i++) @(negedge clk);
        if (valid) begin
            p = prime_out;
            check_val({tag, "_busy_low"}, busy, 0);
        end else begin
            check_val({tag, "_timeout"}, valid, 1);
        end
    endtask

    task automatic directed(input string tag, input logic m, input logic [6:0] c,
                            input logic [6:0] s, input int exp);
        logic [6:0] p;
        issue(m, c, s);
        check_val({tag, "_busy_high"}, busy, 1);
        wait_valid(tag, p);
        check_val({tag, "_prime"}, p, exp);
        @(negedge clk);
        check_val({tag, "_valid_pulse"}, valid, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [6:0] p;
        logic [6:0] s;
        int         expc;
        int         extra;

        req = 0; mode = 0; cand_in = '0; score = '0;
        req4 = 0; mode4 = 0; cand4 = '0; score4 = '0;

        #12;
        check_val("rst_prime", prime_out, 0);
        check_val("rst_valid", valid, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_prime4", p4, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        directed("c24", 1'b1, 7'd24, 7'd12, 29);
        directed("c127", 1'b1, 7'd127, 7'd12, 127);
        directed("c0", 1'b1, 7'd0, 7'd12, 2);
        directed("c1", 1'b1, 7'd1, 7'd12, 2);

        // Level 0 masks 0x7E down to 14; the second req and input changes land mid-search.
        issue(1'b1, 7'h7E, 7'd0);
        check_val("lvl0_busy_high", busy, 1);
        issue(1'b0, 7'h33, 7'd100);
        wait_valid("lvl0", p);
        check_val("lvl0_prime", p, 17);
        extra = 0;
        repeat (60) begin
            @(negedge clk);
            if (valid) extra++;
        end
        check_val("lvl0_single_valid", extra, 0);

        // 4-bit instance: 14 and 15 composite, search wraps to 2.
        mode4 = 1'b1; cand4 = 4'd14; score4 = 7'd0; req4 = 1'b1;
        @(negedge clk);
        req4 = 1'b0;
        for (int i = 0; i < 200 && !v4; i++) @(negedge clk);
        check_val("w4_valid", v4, 1);
        check_val("w4_prime", p4, 2);
        check_val("w4_busy_low", b4, 0);

        // Back-to-back LFSR-driven requests, each new req issued in the valid cycle.
        s = 7'($urandom_range(0, 127));
        expc = ref_prime(int'(lf) & mask_of(int'(s)), 7);
        mode = 1'b0; score = s; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        for (int k = 0; k < 200; k++) begin
            wait_valid("b2b", p);
            check_val("b2b_prime", p, expc);
            check_val("b2b_is_prime", is_prime(int'(p)), 1);
            if (k < 199) begin
                s = 7'($urandom_range(0, 127));
                expc = ref_prime(int'(lf) & mask_of(int'(s)), 7);
                score = s; req = 1'b1;
                @(negedge clk);
                req = 1'b0;
            end else begin
                @(negedge clk);
            end
        end

        // Asynchronous reset in the middle of a TEST run.
        issue(1'b1, 7'd127, 7'd12);
        repeat (3) @(negedge clk);
        check_val("arst_busy_pre", busy, 1);
        #2 rst = 1'b1;
        #1;
        check_val("arst_prime", prime_out, 0);
        check_val("arst_valid", valid, 0);
        check_val("arst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        directed("post_rst", 1'b1, 7'd24, 7'd12, 29);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
